// File: rtl/rotary_pkg.sv
// ---------------------------------------------------------------------------
// rotary_pkg
// Shared definitions for the rotary-encoder emulator and its quadrature
// decoder: FSM state encoding, direction constants and the CW/CCW {A,B}
// phase tables.
// ---------------------------------------------------------------------------
package rotary_pkg;

  // One detent step walks IDLE -> PH1 -> PH2 -> PH3 -> PH4 -> IDLE
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_PH4  = 3'd4
  } rot_state_e;

  localparam logic DIR_CW  = 1'b1;  // A leads B
  localparam logic DIR_CCW = 1'b0;  // B leads A

  // {ROT_A, ROT_B} per phase, clockwise
  localparam logic [1:0] AB_CW_IDLE = 2'b00;
  localparam logic [1:0] AB_CW_PH1  = 2'b10;
  localparam logic [1:0] AB_CW_PH2  = 2'b11;
  localparam logic [1:0] AB_CW_PH3  = 2'b01;
  localparam logic [1:0] AB_CW_PH4  = 2'b00;

  // {ROT_A, ROT_B} per phase, counter-clockwise
  localparam logic [1:0] AB_CCW_IDLE = 2'b00;
  localparam logic [1:0] AB_CCW_PH1  = 2'b01;
  localparam logic [1:0] AB_CCW_PH2  = 2'b11;
  localparam logic [1:0] AB_CCW_PH3  = 2'b10;
  localparam logic [1:0] AB_CCW_PH4  = 2'b00;

  // Channel levels for a given state and direction
  function automatic logic [1:0] ab_for_state(input rot_state_e st, input logic dir);
    logic [1:0] ab;
    ab = 2'b00;
    case (st)
      ST_IDLE: ab = (dir == DIR_CW) ? AB_CW_IDLE : AB_CCW_IDLE;
      ST_PH1:  ab = (dir == DIR_CW) ? AB_CW_PH1  : AB_CCW_PH1;
      ST_PH2:  ab = (dir == DIR_CW) ? AB_CW_PH2  : AB_CCW_PH2;
      ST_PH3:  ab = (dir == DIR_CW) ? AB_CW_PH3  : AB_CCW_PH3;
      ST_PH4:  ab = (dir == DIR_CW) ? AB_CW_PH4  : AB_CCW_PH4;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  // State whose levels were on the wire before entering st
  function automatic rot_state_e prev_phase(input rot_state_e st);
    rot_state_e p;
    p = ST_IDLE;
    case (st)
      ST_PH1:  p = ST_IDLE;
      ST_PH2:  p = ST_PH1;
      ST_PH3:  p = ST_PH2;
      ST_PH4:  p = ST_PH3;
      default: p = ST_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rotary_phase_timer.sv
// ---------------------------------------------------------------------------
// rotary_phase_timer
// Phase-length timer. Counts 0..LIMIT-1 while enabled (LIMIT =
// PHASE_CYCLES + BOUNCE_CYCLES) and wraps to 0 on terminal count, so back-to-
// back phases need no reload. Also flags, one cycle ahead, whether the next
// cycle falls on a "bounce back" slot where the old level must be shown.
// Build option: ROT_BOUNCE_EN enables the bounce-slot flag.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          restart the phase at index 0 (step accept)
//   en            count this cycle
//   tc            pulse on the last cycle of a phase (qualified by en)
//   hold_old_next next cycle's index is an odd bounce slot
// ---------------------------------------------------------------------------
module rotary_phase_timer #(
  parameter int PHASE_CYCLES  = 4,
  parameter int BOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc,
  output logic hold_old_next
);

  localparam int LIMIT = PHASE_CYCLES + BOUNCE_CYCLES;
  localparam int WIDTH = $clog2(LIMIT + 1);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;

  assign tc = en & (count_r == LAST);

  // Next phase index: restart on load, wrap on terminal count, else step
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = {WIDTH{1'b0}};
    end else if (tc) begin
      count_next_s = {WIDTH{1'b0}};
    end else if (en) begin
      count_next_s = count_r + WIDTH'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Phase index register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

`ifdef ROT_BOUNCE_EN
  localparam logic [WIDTH-1:0] BOUNCE_LIM = WIDTH'(BOUNCE_CYCLES);
  // Indices 1,3,5.. inside the bounce window revert to the old level
  assign hold_old_next = (count_next_s < BOUNCE_LIM) & count_next_s[0];
`else
  assign hold_old_next = 1'b0;
`endif

endmodule

// File: rtl/rotary_quadrature_generator.sv
// ---------------------------------------------------------------------------
// rotary_quadrature_generator
// Rotary-encoder emulator: each accepted step request produces one detent of
// Gray-coded ROT_A/ROT_B quadrature (4 phases of PHASE_CYCLES clocks) and
// updates a wrapping signed step counter used as the reference position.
// Build option: ROT_BOUNCE_EN - each phase begins with 2*BOUNCE_COUNT cycles
// of contact bounce on the changing channel (new,old,new,old,...).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   step_req    request one step (sampled while step_ready)
//   step_dir    1 = clockwise (A leads B), latched at accept
//   step_ready  high while idle
//   step_done   one-cycle pulse in the first idle cycle after a step
//   ROT_A/ROT_B registered quadrature outputs
//   step_count  +1 per CW step, -1 per CCW step, wraps
// ---------------------------------------------------------------------------
module rotary_quadrature_generator #(
  parameter int PHASE_CYCLES = 50000,
  parameter int COUNT_W      = 8,
  parameter int BOUNCE_COUNT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_req,
  input  logic               step_dir,
  output logic               step_ready,
  output logic               step_done,
  output logic               ROT_A,
  output logic               ROT_B,
  output logic [COUNT_W-1:0] step_count
);

  import rotary_pkg::*;

`ifdef ROT_BOUNCE_EN
  localparam int BOUNCE_CYCLES = 2 * BOUNCE_COUNT;
`else
  localparam int BOUNCE_CYCLES = 0;
`endif

  rot_state_e         state_r;
  rot_state_e         state_next_s;
  logic               dir_r;
  logic               dir_eff_s;
  logic               accept_s;
  logic               timer_load_s;
  logic               timer_en_s;
  logic               timer_tc_s;
  logic               hold_old_next_s;
  logic               done_next_s;
  logic [1:0]         ab_next_s;
  logic [1:0]         ab_r;
  logic               step_ready_r;
  logic               step_done_r;
  logic [COUNT_W-1:0] step_count_r;

  rotary_phase_timer #(
    .PHASE_CYCLES  (PHASE_CYCLES),
    .BOUNCE_CYCLES (BOUNCE_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .load          (timer_load_s),
    .en            (timer_en_s),
    .tc            (timer_tc_s),
    .hold_old_next (hold_old_next_s)
  );

  // FSM next state, timer control and step completion
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    timer_load_s = 1'b0;
    timer_en_s   = 1'b0;
    done_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (step_req && step_ready_r) begin
          accept_s     = 1'b1;
          timer_load_s = 1'b1;
          state_next_s = ST_PH1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PH1: begin
        timer_en_s   = 1'b1;
        state_next_s = timer_tc_s ? ST_PH2 : ST_PH1;
      end
      ST_PH2: begin
        timer_en_s   = 1'b1;
        state_next_s = timer_tc_s ? ST_PH3 : ST_PH2;
      end
      ST_PH3: begin
        timer_en_s   = 1'b1;
        state_next_s = timer_tc_s ? ST_PH4 : ST_PH3;
      end
      ST_PH4: begin
        timer_en_s = 1'b1;
        if (timer_tc_s) begin
          done_next_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PH4;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Direction for the next cycle's levels: a fresh accept uses the live input
  assign dir_eff_s = accept_s ? step_dir : dir_r;

  // Next-cycle channel levels; bounce slots show the previous phase's levels
  always_comb begin
    ab_next_s = ab_for_state(state_next_s, dir_eff_s);
    if ((state_next_s != ST_IDLE) && hold_old_next_s) begin
      ab_next_s = ab_for_state(prev_phase(state_next_s), dir_eff_s);
    end else begin
      ab_next_s = ab_for_state(state_next_s, dir_eff_s);
    end
  end

  // FSM state and latched direction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      dir_r   <= DIR_CCW;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        dir_r <= step_dir;
      end else begin
        dir_r <= dir_r;
      end
    end
  end

  // Registered outputs and position counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ab_r         <= 2'b00;
      step_ready_r <= 1'b1;
      step_done_r  <= 1'b0;
      step_count_r <= {COUNT_W{1'b0}};
    end else begin
      ab_r         <= ab_next_s;
      step_ready_r <= (state_next_s == ST_IDLE);
      step_done_r  <= done_next_s;
      if (done_next_s) begin
        step_count_r <= (dir_r == DIR_CW) ? (step_count_r + COUNT_W'(1))
                                          : (step_count_r - COUNT_W'(1));
      end else begin
        step_count_r <= step_count_r;
      end
    end
  end

  assign ROT_A      = ab_r[1];
  assign ROT_B      = ab_r[0];
  assign step_ready = step_ready_r;
  assign step_done  = step_done_r;
  assign step_count = step_count_r;

endmodule
